nand_test_sequencer: RTL and testbench

- Self-checking stimulus controller for a 2-input combinational gate under test (nand_gate by default).
- Steps through every input vector and drives the gate inputs. Waits a programmable settle time, samples the gate output and compares it against an expected truth table.
- Reports pass/fail, mismatch count and the first failing vector.
- Sits between a run-control source (bench or host register) and the gate, so gate checks run as synthesizable on-chip BIST instead of in a hand-written bench.

---
 rtl/nand_test_pkg.sv | 23 ++
 rtl/settle_timer.sv | 26 ++
 rtl/nand_test_sequencer.sv | 132 +++++++++++++
 tb/tb_nand_test_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_test_pkg.sv
// Shared definitions for the gate self-test sequencer: state encoding and
// expected truth tables for the 2-input gates in this codebase.
package nand_test_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_APPLY  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    APPLY  = ST_APPLY,
    SETTLE = ST_SETTLE,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } state_t;

  // Bit i is the expected gate output when vector i is applied.
  localparam logic [3:0] NAND_EXP_2IN = 4'b0111;
  localparam logic [3:0] AND_EXP_2IN  = 4'b1000;

endpackage

// File: rtl/settle_timer.sv
// Loadable 8-bit down-counter; zero flags that the settle interval has elapsed.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_r;

  // Load takes priority; counting stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != 8'd0)) begin
      cnt_r <= cnt_r - 8'd1;
    end
  end

  assign zero = (cnt_r == 8'd0);

endmodule

// File: rtl/nand_test_sequencer.sv
// On-chip self-test for a 2-input combinational gate: walks every input vector,
// samples the gate output after a settle time and records mismatches.
module nand_test_sequencer
  import nand_test_pkg::*;
#(
  parameter int                   NUM_IN        = 2,
  parameter int                   SETTLE_CYCLES = 4,
  parameter logic [2**NUM_IN-1:0] EXP_TABLE     = NAND_EXP_2IN
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  output logic [NUM_IN-1:0]                 vec_out,
  input  logic                              y_in,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [$clog2(2**NUM_IN+1)-1:0]    err_count,
  output logic [NUM_IN-1:0]                 fail_idx,
  output logic                              fail_valid
);

  localparam int NUM_VEC = 2**NUM_IN;
  localparam int CW      = $clog2(NUM_VEC + 1);

  localparam logic [NUM_IN-1:0] LAST_IDX   = NUM_IN'(NUM_VEC - 1);
  localparam logic [CW-1:0]     ERR_MAX    = CW'(NUM_VEC);
  localparam logic [7:0]        SETTLE_LD  = 8'(SETTLE_CYCLES - 1);

  state_t            state_r;
  logic [NUM_IN-1:0] idx_r;
  logic              timer_load_s;
  logic              timer_en_s;
  logic              timer_zero_s;
  logic              mismatch_s;
  logic              running_s;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .en       (timer_en_s),
    .load_val (SETTLE_LD),
    .zero     (timer_zero_s)
  );

  // Timer control and output comparison decoded from the current state.
  always_comb begin
    timer_load_s = (state_r == APPLY);
    timer_en_s   = (state_r == SETTLE);
    running_s    = (state_r == APPLY) || (state_r == SETTLE) || (state_r == SAMPLE);
    mismatch_s   = (y_in != EXP_TABLE[idx_r]);
  end

  // Sequencer FSM with registered outputs and result bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      vec_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_idx   <= '0;
      fail_valid <= 1'b0;
    end else if (abort && running_s) begin
      // Partial results are kept for inspection; pass stays cleared.
      state_r <= IDLE;
      busy    <= 1'b0;
      vec_out <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done    <= 1'b0;
          vec_out <= '0;
          if (start && !abort) begin
            state_r    <= APPLY;
            idx_r      <= '0;
            err_count  <= '0;
            fail_idx   <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        APPLY: begin
          vec_out <= idx_r;
          state_r <= SETTLE;
        end
        SETTLE: begin
          if (timer_zero_s) begin
            state_r <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (mismatch_s) begin
            if (err_count != ERR_MAX) begin
              err_count <= err_count + CW'(1);
            end
            if (!fail_valid) begin
              fail_idx   <= idx_r;
              fail_valid <= 1'b1;
            end
          end
          if (idx_r == LAST_IDX) begin
            state_r <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            pass    <= (err_count == '0) && !mismatch_s;
          end else begin
            idx_r   <= idx_r + NUM_IN'(1);
            state_r <= APPLY;
          end
        end
        DONE: begin
          done    <= 1'b0;
          vec_out <= '0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          vec_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_test_sequencer.sv
// Directed self-checking bench for nand_test_sequencer with a modelled NAND
// gate that can be forced stuck-at-1 or stuck-at-0.
module tb_nand_test_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [1:0] vec_out;
  logic       y_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_idx;
  logic       fail_valid;
  logic [1:0] mode;

  int n_checks;
  int n_fail;

  nand_test_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .vec_out    (vec_out),
    .y_in       (y_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_idx   (fail_idx),
    .fail_valid (fail_valid)
  );

  // mode 0: good NAND, 1: stuck-at-1, 2: stuck-at-0
  assign y_in = (mode == 2'd0) ? ~&vec_out : (mode == 2'd1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Starts a run and returns the edge count (after the start edge) at which done was seen, or -1.
  task automatic run_until_done(output int k_done);
    k_done = -1;
    pulse_start();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done === 1'b1 && k_done < 0) k_done = k;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'd0;
    repeat (3) tick();
    n_checks++;
    if ({vec_out, busy, done, pass, err_count, fail_idx, fail_valid} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {vec_out, busy, done, pass, err_count, fail_idx, fail_valid});
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_good_nand();
    logic [1:0] exp_vec;
    mode = 2'd0;
    pulse_start();
    for (int k = 1; k <= 26; k++) begin
      tick();
      exp_vec = (k <= 24) ? 2'((k - 1) / 6) : 2'd0;
      n_checks++;
      if (vec_out !== exp_vec) begin
        n_fail++;
        $display("FAIL good_vec_out k=%0d: got %0d expected %0d", k, vec_out, exp_vec);
      end
      n_checks++;
      if (busy !== (k <= 23)) begin
        n_fail++;
        $display("FAIL good_busy k=%0d: got %0d expected %0d", k, busy, (k <= 23));
      end
      n_checks++;
      if (done !== (k == 24)) begin
        n_fail++;
        $display("FAIL good_done k=%0d: got %0d expected %0d", k, done, (k == 24));
      end
    end
    n_checks++;
    if ({pass, err_count, fail_valid} !== 5'b1_000_0) begin
      n_fail++;
      $display("FAIL good_result: got pass=%0d err=%0d fv=%0d expected 1 0 0", pass, err_count, fail_valid);
    end
  endtask

  task automatic test_stuck(input logic [1:0] m, input logic [2:0] exp_err, input logic [1:0] exp_idx);
    int kd;
    mode = m;
    run_until_done(kd);
    n_checks++;
    if (kd != 24) begin
      n_fail++;
      $display("FAIL stuck%0d_done_edge: got %0d expected 24", m, kd);
    end
    n_checks++;
    if (err_count !== exp_err) begin
      n_fail++;
      $display("FAIL stuck%0d_err_count: got %0d expected %0d", m, err_count, exp_err);
    end
    n_checks++;
    if (fail_idx !== exp_idx || fail_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck%0d_fail_idx: got %0d/%0d expected %0d/1", m, fail_idx, fail_valid, exp_idx);
    end
    n_checks++;
    if (pass !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck%0d_pass: got %0d expected 0", m, pass);
    end
    mode = 2'd0;
  endtask

  task automatic test_start_during_settle();
    int n_done;
    n_done = 0;
    mode = 2'd0;
    pulse_start();
    for (int k = 1; k <= 40; k++) begin
      start = (k == 8);
      tick();
      if (done === 1'b1) begin
        n_done++;
        n_checks++;
        if (k != 24) begin
          n_fail++;
          $display("FAIL ignore_start_done_edge: got %0d expected 24", k);
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (n_done != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_count: got done=%0d busy=%0d expected 1 0", n_done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    n_done = 0;
    mode  = 2'd0;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 56; k++) begin
      if (k == 30) start = 1'b0;
      tick();
      if (done === 1'b1) n_done++;
      n_checks++;
      if (done !== (k == 24 || k == 50)) begin
        n_fail++;
        $display("FAIL b2b_done k=%0d: got %0d expected %0d", k, done, (k == 24 || k == 50));
      end
      if (k == 24 || k == 50) begin
        n_checks++;
        if (pass !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_pass k=%0d: got %0d expected 1", k, pass);
        end
      end
      if (k == 25 || k == 26) begin
        n_checks++;
        if (busy !== (k == 26)) begin
          n_fail++;
          $display("FAIL b2b_restart_busy k=%0d: got %0d expected %0d", k, busy, (k == 26));
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (n_done != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d expected 2", n_done);
    end
  endtask

  task automatic test_abort();
    int n_done;
    n_done = 0;
    mode = 2'd2;
    pulse_start();
    repeat (14) tick();
    n_checks++;
    if (vec_out !== 2'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got vec=%0d busy=%0d expected 2 1", vec_out, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, vec_out, done, pass} !== 5'd0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%0d vec=%0d done=%0d pass=%0d expected 0 0 0 0",
               busy, vec_out, done, pass);
    end
    n_checks++;
    if (err_count !== 3'd2 || fail_idx !== 2'd0 || fail_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_partial: got err=%0d idx=%0d fv=%0d expected 2 0 1", err_count, fail_idx, fail_valid);
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", n_done);
    end
    mode = 2'd0;
  endtask

  task automatic test_reset_mid_sample();
    int n_done;
    n_done = 0;
    mode = 2'd2;
    pulse_start();
    repeat (11) tick();
    n_checks++;
    if (vec_out !== 2'd1 || busy !== 1'b1 || err_count !== 3'd1) begin
      n_fail++;
      $display("FAIL rst_pre: got vec=%0d busy=%0d err=%0d expected 1 1 1", vec_out, busy, err_count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({vec_out, busy, done, pass, err_count, fail_idx, fail_valid} !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_async: got %b expected all zero",
               {vec_out, busy, done, pass, err_count, fail_idx, fail_valid});
    end
    tick();
    #3 rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL rst_no_done: got %0d active cycles expected 0", n_done);
    end
    mode = 2'd0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_good_nand();
    repeat (2) tick();
    test_stuck(2'd1, 3'd1, 2'd3);
    test_stuck(2'd2, 3'd3, 2'd0);
    test_start_during_settle();
    repeat (2) tick();
    test_back_to_back();
    repeat (2) tick();
    test_abort();
    test_reset_mid_sample();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
